// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_words, input int sets);
    return 30 - off_w(line_words) - idx_w(sets);
  endfunction

  // A single-way cache still needs a 1-bit way/pointer field.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_assoc_if;
  logic        req_valid;
  logic [29:0] req_addr;
  logic        flush;
  logic        is_hit;
  logic [31:0] rdata;
  logic        busy;
  logic        mem_req_valid;
  logic [29:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output is_hit, rdata, busy, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  is_hit, rdata, busy, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_way.sv
// One cache way: valid bits, tag and data arrays, and the lookup compare.
module icache_way
  import icache_pkg::*;
#(
  parameter  int SETS       = 8,
  parameter  int LINE_WORDS = 4,
  localparam int OFF_W      = off_w(LINE_WORDS),
  localparam int IDX_W      = idx_w(SETS),
  localparam int TAG_W      = tag_w(LINE_WORDS, SETS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic [OFF_W-1:0] lk_off,
  output logic             lk_valid,
  output logic             lk_hit,
  output logic [31:0]      lk_word,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             data_we,
  input  logic             tag_we,
  input  logic             inv_we,
  input  logic             flush_all
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS][LINE_WORDS];

  // flush_all outranks a same-edge line completion so a flushed refill ends invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          valid <= '0;
    else if (flush_all) valid <= '0;
    else if (tag_we)    valid[wr_idx] <= 1'b1;
    else if (inv_we)    valid[wr_idx] <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (tag_we)  tags[wr_idx] <= wr_tag;
    if (data_we) data[wr_idx][wr_off] <= wr_data;
  end

  assign lk_valid = valid[lk_idx];
  assign lk_hit   = lk_valid && (tags[lk_idx] == lk_tag);
  assign lk_word  = data[lk_idx][lk_off];

endmodule

// File: rtl/icache_assoc.sv
// Blocking set-associative instruction cache: combinational hit, word-at-a-time
// line refill with round-robin replacement, and deferred flush during refill.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic           clock,
  input  logic           reset,
  icache_assoc_if.slave  bus
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(LINE_WORDS, SETS);
  localparam int WAY_W = way_w(WAYS);

  if (!is_pow2(WAYS) || !is_pow2(SETS) || SETS < 2 ||
      !is_pow2(LINE_WORDS) || LINE_WORDS < 2) begin : g_bad_param
    $fatal(1, "icache_assoc: WAYS, SETS, LINE_WORDS must be powers of two; SETS, LINE_WORDS >= 2");
  end

  state_e state, state_nx;

  logic [TAG_W-1:0] req_tag, lat_tag;
  logic [IDX_W-1:0] req_idx, lat_idx, wr_idx;
  logic [OFF_W-1:0] req_off, word_cnt;
  logic [WAY_W-1:0] victim, victim_nx;
  logic             flush_pend;
  logic [SETS-1:0][WAY_W-1:0] rr_ptr;

  logic [WAYS-1:0]        way_hit, way_valid, data_we, tag_we, inv_we;
  logic [WAYS-1:0][31:0]  way_word;

  logic idle, lookup, any_hit, miss_start, resp_take, last_word, fill_done, flush_now;

  assign {req_tag, req_idx, req_off} = bus.req_addr;

  assign idle       = (state == S_IDLE);
  assign lookup     = idle && bus.req_valid && !bus.flush;
  assign any_hit    = |way_hit;
  assign miss_start = lookup && !any_hit;
  assign resp_take  = (state == S_WAIT) && bus.mem_resp_valid;
  assign last_word  = (word_cnt == OFF_W'(LINE_WORDS - 1));
  assign fill_done  = resp_take && last_word;
  assign flush_now  = (idle && bus.flush) || (fill_done && (flush_pend || bus.flush));
  assign wr_idx     = idle ? req_idx : lat_idx;

  // Lowest invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    victim_nx = rr_ptr[req_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_valid[w]) victim_nx = WAY_W'(w);
  end

  always_comb begin
    data_we = '0;
    tag_we  = '0;
    inv_we  = '0;
    for (int w = 0; w < WAYS; w++) begin
      data_we[w] = resp_take  && (victim    == WAY_W'(w));
      tag_we[w]  = fill_done  && (victim    == WAY_W'(w));
      inv_we[w]  = miss_start && (victim_nx == WAY_W'(w));
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_way (
      .clock     (clock),
      .reset     (reset),
      .lk_idx    (req_idx),
      .lk_tag    (req_tag),
      .lk_off    (req_off),
      .lk_valid  (way_valid[w]),
      .lk_hit    (way_hit[w]),
      .lk_word   (way_word[w]),
      .wr_idx    (wr_idx),
      .wr_off    (word_cnt),
      .wr_tag    (lat_tag),
      .wr_data   (bus.mem_resp_data),
      .data_we   (data_we[w]),
      .tag_we    (tag_we[w]),
      .inv_we    (inv_we[w]),
      .flush_all (flush_now)
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_tag    <= '0;
      lat_idx    <= '0;
      victim     <= '0;
      word_cnt   <= '0;
      flush_pend <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      if (miss_start) begin
        lat_tag  <= req_tag;
        lat_idx  <= req_idx;
        victim   <= victim_nx;
        word_cnt <= '0;
      end else if (resp_take) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end

      if (flush_now)              flush_pend <= 1'b0;
      else if (!idle && bus.flush) flush_pend <= 1'b1;

      if (flush_now)
        rr_ptr <= '0;
      else if (fill_done)
        rr_ptr[lat_idx] <= (rr_ptr[lat_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[lat_idx] + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (miss_start)         state_nx = S_REQ;
      S_REQ:   if (bus.mem_req_ready)  state_nx = S_WAIT;
      S_WAIT:  if (bus.mem_resp_valid) state_nx = last_word ? S_IDLE : S_REQ;
      default:                         state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy          = !idle;
    bus.mem_req_valid = (state == S_REQ);
    bus.mem_req_addr  = (state == S_REQ) ? {lat_tag, lat_idx, word_cnt} : '0;
    bus.is_hit        = lookup && any_hit;
    bus.rdata         = '0;
    for (int w = 0; w < WAYS; w++)
      if (lookup && way_hit[w]) bus.rdata |= way_word[w];
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: fetch driver, latency-configurable memory model,
// and a queue-based monitor checking memory requests and hit data.
module tb_icache_assoc;
  import icache_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  icache_assoc_if bus();

  icache_assoc #(.WAYS(2), .SETS(8), .LINE_WORDS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ready_dly = 0;
  int resp_dly  = 0;
  logic [29:0] exp_mem [$];
  logic [31:0] exp_hit [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_line(input logic [29:0] base);
    for (int i = 0; i < 4; i++) exp_mem.push_back(base + 30'(i));
  endtask

  // Holds the request until a hit; returns at posedge+1 with req_valid low.
  task automatic fetch(input logic [29:0] a, input logic [31:0] d, input int lat);
    int seen = -1;
    exp_hit.push_back(d);
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (bus.is_hit) begin
        seen = k;
        break;
      end
      @(posedge clock); #1;
    end
    if (seen < 0) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: addr %h got no hit, expected hit after %0d cycles", a, lat);
      exp_hit.delete();
    end else begin
      check("hit_latency", 32'(seen), 32'(lat));
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  // Memory: ready after ready_dly REQ cycles, response resp_dly cycles into WAIT.
  initial begin : mem_model
    logic [29:0] a;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    @(posedge clock); #1;
    forever begin
      if (bus.mem_req_valid) begin
        a = bus.mem_req_addr;
        repeat (ready_dly) begin @(posedge clock); #1; end
        bus.mem_req_ready = 1'b1;
        @(posedge clock); #1;
        bus.mem_req_ready = 1'b0;
        repeat (resp_dly) begin @(posedge clock); #1; end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hC0DE_0000 ^ {2'b00, a};
        @(posedge clock); #1;
        bus.mem_resp_valid = 1'b0;
      end else begin
        @(posedge clock); #1;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_mem.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_req_unexpected: got %h expected no request", bus.mem_req_addr);
        end else begin
          check("mem_req_addr", {2'b00, bus.mem_req_addr}, {2'b00, exp_mem.pop_front()});
        end
      end
      if (bus.is_hit) begin
        if (exp_hit.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hit_unexpected: got hit rdata %h expected no hit", bus.rdata);
        end else begin
          check("hit_rdata", bus.rdata, exp_hit.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clock); #1;
    check("rst_is_hit", 32'(bus.is_hit), 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 0);
    check("rst_mem_req_addr", 32'(bus.mem_req_addr), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Cold miss, same-line hit, then two-way conflict in set 0.
    expect_line(30'h40);  fetch(30'h40, 32'hC0DE_0040, 9);
    fetch(30'h43, 32'hC0DE_0043, 0);
    expect_line(30'h80);  fetch(30'h80, 32'hC0DE_0080, 9);
    expect_line(30'hC0);  fetch(30'hC0, 32'hC0DE_00C0, 9);
    fetch(30'h81, 32'hC0DE_0081, 0);
    fetch(30'hC2, 32'hC0DE_00C2, 0);
    expect_line(30'h40);  fetch(30'h40, 32'hC0DE_0040, 9);

    // Flush in IDLE suppresses a hit, and a coincident miss starts no refill.
    bus.req_addr = 30'hC0; bus.req_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clock);
    check("flush_is_hit", 32'(bus.is_hit), 0);
    check("flush_rdata", bus.rdata, 0);
    @(posedge clock); #1;
    bus.req_addr = 30'h1C0;
    @(negedge clock);
    check("flush_miss_is_hit", 32'(bus.is_hit), 0);
    @(posedge clock); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clock);
    check("flush_miss_busy", 32'(bus.busy), 0);
    check("flush_miss_mem_req", 32'(bus.mem_req_valid), 0);
    @(posedge clock); #1;
    expect_line(30'hC0);  fetch(30'hC0, 32'hC0DE_00C0, 9);

    // Flush mid-refill: the finished line is dropped, so the held request refills again.
    expect_line(30'h40); expect_line(30'h40);
    fork
      fetch(30'h40, 32'hC0DE_0040, 18);
      begin
        repeat (3) @(posedge clock); #1;
        bus.flush = 1'b1;
        @(posedge clock); #1;
        bus.flush = 1'b0;
      end
    join
    expect_line(30'hC0);  fetch(30'hC0, 32'hC0DE_00C0, 9);

    // Backpressure: request address must hold while ready is low.
    ready_dly = 5; resp_dly = 3;
    expect_line(30'h100);
    fork
      fetch(30'h100, 32'hC0DE_0100, 41);
      begin
        @(negedge clock);
        repeat (5) begin
          @(negedge clock);
          check("bp_mem_req_valid", 32'(bus.mem_req_valid), 1);
          check("bp_mem_req_addr", 32'(bus.mem_req_addr), 32'h100);
        end
      end
    join
    ready_dly = 0;

    // Reset while waiting for the first response word.
    exp_mem.push_back(30'h140);
    bus.req_addr = 30'h140; bus.req_valid = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("wait_busy", 32'(bus.busy), 1);
    @(posedge clock); #1;
    reset = 1'b1; bus.req_valid = 1'b0;
    #1;
    check("mid_rst_is_hit", 32'(bus.is_hit), 0);
    check("mid_rst_rdata", bus.rdata, 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_mem_req_valid", 32'(bus.mem_req_valid), 0);
    check("mid_rst_mem_req_addr", 32'(bus.mem_req_addr), 0);
    repeat (3) @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;
    resp_dly = 0;
    expect_line(30'h140); fetch(30'h140, 32'hC0DE_0140, 9);

    repeat (3) @(posedge clock); #1;
    check("exp_mem_drained", 32'(exp_mem.size()), 0);
    check("exp_hit_drained", 32'(exp_hit.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter WAYS, 2, associativity; power of two, >=1.
REQ-002 Parameter SETS, 8, sets per way; power of two, >=2.
REQ-003 Parameter LINE_WORDS, 4, 32-bit words per line; power of two, >=2.
REQ-004 One clock; reset is asynchronous and active-high. Ports are clock and reset, in that order first.
REQ-005 Port clock, input, 1, rising-edge clock.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port req_valid, input, 1, fetch request present.
REQ-008 Port req_addr, input, 30, word address [31:2].
REQ-009 Port flush, input, 1, invalidate all lines.
REQ-010 Port is_hit, output, 1, combinational hit.
REQ-011 Port rdata, output, 32, hit word; 0 when no hit.
REQ-012 Port busy, output, 1, refill or pending flush in progress.
REQ-013 Port mem_req_valid, output, 1, memory word-read request.
REQ-014 Port mem_req_addr, output, 30, requested word address.
REQ-015 Port mem_req_ready, input, 1, memory accepts request.
REQ-016 Port mem_resp_valid, input, 1, response word valid.
REQ-017 Port mem_resp_data, input, 32, response word.

Function
REQ-018 Address split: offset = low OFF_W=log2(LINE_WORDS) bits, index = next IDX_W=log2(SETS) bits, tag = remaining TAG_W=30-OFF_W-IDX_W bits.
REQ-019 FSM states: IDLE, REQ, WAIT; busy=1 in REQ/WAIT.
REQ-020 IDLE hit: req_valid, flush=0, and any valid way in indexed set with matching tag -> same-cycle is_hit=1, rdata = that way's word at offset; else is_hit=0, rdata=0.
REQ-021 is_hit SHALL be 0 in REQ/WAIT regardless of inputs; requests are ignored while busy, and the requester holds req_addr until hit.
REQ-022 IDLE miss (req_valid, no hit, flush=0): latch tag/index, select victim, word_cnt=0, go to REQ.
REQ-023 Victim selection: lowest-index invalid way in the set; if none, the set's round-robin pointer.
REQ-024 REQ: mem_req_valid=1, mem_req_addr={tag,index,word_cnt}; on mem_req_ready go to WAIT.
REQ-025 WAIT: on mem_resp_valid write mem_resp_data into victim word word_cnt; if word_cnt != LINE_WORDS-1, increment and go to REQ; else write tag, set valid, advance the set's pointer modulo WAYS, go to IDLE.
REQ-026 A line SHALL be invalid during its refill; a partial line never hits.
REQ-027 mem_resp_valid outside WAIT is ignored.
REQ-028 Zero-wait memory (ready in REQ cycle, response in next cycle): miss detected cycle T, hit returned at T+2*LINE_WORDS+1 (T+9 at default).
REQ-029 flush in IDLE: all valid bits and pointers cleared at the next edge; is_hit=0 in the flush cycle.
REQ-030 flush in REQ/WAIT: latched as pending, busy held; refill completes, then all valid bits (including the new line) and pointers are cleared in the same edge.
REQ-031 flush coincident with a miss in IDLE: flush wins, no refill starts.

Reset
REQ-032 Reset SHALL clear all valid bits and round-robin pointers, set state to IDLE, word_cnt=0, and clear flush-pending.
REQ-033 Reset drives is_hit=0, rdata=0, busy=0, mem_req_valid=0, mem_req_addr=0.
REQ-034 Tag and data arrays are not reset.
REQ-035 Reset mid-refill aborts it, and no line becomes valid.

Structure
REQ-036 Package icache_pkg holds the state enum and the OFF_W/IDX_W/TAG_W derivation functions.
REQ-037 Sub-module icache_way (one way's valid/tag/data storage plus tag compare) is instantiated WAYS times.
REQ-038 Elaboration SHALL fail for non-power-of-two parameters.

Verification (defaults)
REQ-039 Cold miss: fetch 0x0000_0100 -> requests 0x100, 0x104, 0x108, 0x10C in order; hit at T+9 with the word from 0x100.
REQ-040 Same-line hits: after REQ-039, fetch 0x10C -> immediate is_hit=1, rdata = fourth response word.
REQ-041 Conflict: fill 0x100, 0x200 (same set, both ways), then 0x300 -> evicts the way of 0x100; 0x200 still hits, 0x100 misses.
REQ-042 Flush: flush mid-refill of 0x100 -> refill finishes, busy drops, then 0x100 misses.
REQ-043 Backpressure: mem_req_ready low 5 cycles, response 3 cycles late -> mem_req_addr held stable, no hit until the line completes.
REQ-044 Reset asserted in WAIT -> outputs 0 next, and a subsequent fetch of the same address misses.
